// File: rtl/fib_seq.sv
// Operand sequencer for the lab01 ALU: feeds a_reg/b_reg to the ALU and shifts the
// result back in, producing b' = a op b, a' = b for a programmed number of terms.
module fib_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] init_a,
    input  logic [WIDTH-1:0] init_b,
    input  logic [CNT_W-1:0] n,
    input  logic [4:0]       op_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] term,
    output logic             term_valid,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_lat;
    logic [4:0]       op_lat;
    logic             ovf_now;
    logic             last_term;

    // Signed overflow of the result being registered this cycle
    always_comb begin
        ovf_now = 1'b0;
        case (op_lat)
            OP_ADD:  ovf_now = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                               (alu_out[WIDTH-1] != a_reg[WIDTH-1]);
            OP_SUB:  ovf_now = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                               (alu_out[WIDTH-1] != a_reg[WIDTH-1]);
            default: ovf_now = 1'b0;
        endcase
    end

    // Compare before increment so n = 2^CNT_W-1 terminates without cnt wrapping
    assign last_term = (cnt == n_lat - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            term       <= '0;
            term_valid <= 1'b0;
            cnt        <= '0;
            n_lat      <= '0;
            op_lat     <= OP_NOP;
            ovf        <= 1'b0;
        end else begin
            term_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg  <= init_a;
                        b_reg  <= init_b;
                        n_lat  <= n;
                        op_lat <= op_sel;
                        cnt    <= '0;
                        ovf    <= 1'b0;
                        state  <= (n != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    a_reg      <= b_reg;
                    b_reg      <= alu_out;
                    term       <= alu_out;
                    term_valid <= 1'b1;
                    cnt        <= cnt + CNT_W'(1);
                    if (ovf_now)
                        ovf <= 1'b1;
                    if (last_term)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign alu_a  = a_reg;
    assign alu_b  = b_reg;
    assign alu_op = (state == S_RUN) ? op_lat : OP_NOP;
    // busy spans the whole run including the closing DONE cycle
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

endmodule

// File: tb/tb_fib_seq.sv
// Directed bench for fib_seq with a small ALU stub on the alu_* loop.
module tb_fib_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] init_a, init_b;
    logic [7:0]  n;
    logic [4:0]  op_sel;
    logic [31:0] alu_a, alu_b, alu_out, term;
    logic [4:0]  alu_op;
    logic        term_valid, busy, done, ovf;

    int checks = 0;
    int failures = 0;

    fib_seq #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_a(init_a), .init_b(init_b),
        .n(n), .op_sel(op_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .term(term), .term_valid(term_valid), .busy(busy),
        .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // ALU stub: ADD, SUB, everything else passes operand a
    always_comb begin
        case (alu_op)
            5'h01:   alu_out = alu_a + alu_b;
            5'h02:   alu_out = alu_a - alu_b;
            default: alu_out = alu_a;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge (E0); returns 1 time unit after E0
    task automatic kick(input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] len, input logic [4:0] op);
        init_a = a; init_b = b; n = len; op_sel = op; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; init_a = '0; init_b = '0; n = '0; op_sel = '0;
        #3;
        checks++;
        if ({alu_a, alu_b, alu_op, term, term_valid, busy, done, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {alu_a, alu_b, alu_op, term, term_valid, busy, done, ovf});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, done, term_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got=%b want=000", {busy, done, term_valid});
        end
    endtask

    task automatic test_fib_add();
        logic [31:0] exp_t [10];
        int busy_cnt;
        exp_t = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
        kick(32'd0, 32'd1, 8'd10, 5'h01);
        busy_cnt = busy ? 1 : 0;
        checks++;
        if (alu_op !== 5'h01) begin
            failures++; $display("FAIL fib_alu_op got=%h want=01", alu_op);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (busy) busy_cnt++;
            checks++;
            if (term_valid !== 1'b1 || term !== exp_t[k-1] || done !== (k == 10)) begin
                failures++;
                $display("FAIL fib_term%0d got tv=%b term=%0d done=%b want tv=1 term=%0d done=%b",
                         k, term_valid, term, done, exp_t[k-1], (k == 10));
            end
        end
        tick();
        if (busy) busy_cnt++;
        checks++;
        if (busy_cnt != 11 || done !== 1'b0 || term_valid !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL fib_end got busy_cycles=%0d done=%b tv=%b ovf=%b want 11 0 0 0",
                     busy_cnt, done, term_valid, ovf);
        end
    endtask

    task automatic test_sub();
        logic [31:0] exp_t [3];
        exp_t = '{32'd7, 32'hFFFF_FFFC, 32'd11};
        kick(32'd10, 32'd3, 8'd3, 5'h02);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (alu_op !== 5'h02) begin
                failures++; $display("FAIL sub_alu_op_run got=%h want=02", alu_op);
            end
            tick();
            checks++;
            if (term_valid !== 1'b1 || term !== exp_t[k-1]) begin
                failures++;
                $display("FAIL sub_term%0d got tv=%b term=%h want tv=1 term=%h",
                         k, term_valid, term, exp_t[k-1]);
            end
        end
        checks++;
        if (done !== 1'b1 || alu_op !== 5'h00 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_done got done=%b alu_op=%h ovf=%b want 1 00 0", done, alu_op, ovf);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || alu_op !== 5'h00) begin
            failures++; $display("FAIL sub_idle got busy=%b alu_op=%h want 0 00", busy, alu_op);
        end
    endtask

    task automatic test_overflow_and_zero();
        kick(32'h4000_0000, 32'h4000_0000, 8'd2, 5'h01);
        checks++;
        if (ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_early got=%b want=0", ovf);
        end
        tick();
        checks++;
        if (term !== 32'h8000_0000 || ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_term1 got term=%h ovf=%b want 80000000 1", term, ovf);
        end
        tick();
        checks++;
        if (term !== 32'hC000_0000 || ovf !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL ovf_term2 got term=%h ovf=%b done=%b want c0000000 1 1", term, ovf, done);
        end
        tick();
        checks++;
        if (ovf !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL ovf_sticky got ovf=%b done=%b want 1 0", ovf, done);
        end
        // zero-length run: clears ovf, only a done pulse
        kick(32'd5, 32'd6, 8'd0, 5'h01);
        checks++;
        if (done !== 1'b1 || term_valid !== 1'b0 || ovf !== 1'b0 || term !== 32'hC000_0000) begin
            failures++;
            $display("FAIL zero_done got done=%b tv=%b ovf=%b term=%h want 1 0 0 c0000000",
                     done, term_valid, ovf, term);
        end
        tick();
        checks++;
        if (done !== 1'b0 || term_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_after got done=%b tv=%b busy=%b want 0 0 0", done, term_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_t [5];
        exp_t = '{1, 2, 3, 5, 8};
        kick(32'd0, 32'd1, 8'd5, 5'h01);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (term_valid !== 1'b1 || term !== exp_t[k-1] || done !== (k == 5)) begin
                failures++;
                $display("FAIL b2b_term%0d got tv=%b term=%0d done=%b want 1 %0d %b",
                         k, term_valid, term, done, exp_t[k-1], (k == 5));
            end
            if (k == 2) begin
                init_a = 32'd100; init_b = 32'd200; n = 8'd3; start = 1'b1;
            end else if (k == 3) begin
                start = 1'b0;
            end else if (k == 4) begin
                init_a = 32'd2; init_b = 32'd3; n = 8'd1; op_sel = 5'h01; start = 1'b1;
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || alu_a !== 32'd2 || alu_b !== 32'd3) begin
            failures++;
            $display("FAIL b2b_restart got busy=%b a=%0d b=%0d want 1 2 3", busy, alu_a, alu_b);
        end
        tick();
        checks++;
        if (term_valid !== 1'b1 || term !== 32'd5 || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second got tv=%b term=%0d done=%b want 1 5 1", term_valid, term, done);
        end
        tick();
    endtask

    task automatic test_unknown_op();
        kick(32'd7, 32'd9, 8'd2, 5'h1F);
        checks++;
        if (alu_op !== 5'h1F) begin
            failures++; $display("FAIL unk_alu_op got=%h want=1f", alu_op);
        end
        tick();
        checks++;
        if (term !== 32'd7) begin
            failures++; $display("FAIL unk_term1 got=%0d want=7", term);
        end
        tick();
        checks++;
        if (term !== 32'd9 || done !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL unk_term2 got term=%0d done=%b ovf=%b want 9 1 0", term, done, ovf);
        end
        tick();
    endtask

    task automatic test_max_n();
        int tv_cnt = 0;
        int done_at = -1;
        kick(32'd0, 32'd0, 8'd255, 5'h1F);
        for (int c = 1; c <= 300 && done_at < 0; c++) begin
            tick();
            if (term_valid) tv_cnt++;
            if (done) done_at = c;
        end
        checks++;
        if (tv_cnt != 255 || done_at != 255) begin
            failures++;
            $display("FAIL max_n got terms=%0d done_at=%0d want 255 255", tv_cnt, done_at);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0;
        kick(32'd0, 32'd1, 8'd8, 5'h01);
        repeat (3) tick();
        checks++;
        if (term !== 32'd3) begin
            failures++; $display("FAIL rst_pre got term=%0d want=3", term);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, term, term_valid, busy, done, ovf} !== '0) begin
            failures++;
            $display("FAIL rst_async got=%h want=0",
                     {alu_a, alu_b, alu_op, term, term_valid, busy, done, ovf});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            tick();
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_no_done got done_cycles=%0d busy=%b want 0 0", done_seen, busy);
        end
        kick(32'd0, 32'd1, 8'd2, 5'h01);
        tick();
        checks++;
        if (term_valid !== 1'b1 || term !== 32'd1) begin
            failures++; $display("FAIL rst_fresh1 got tv=%b term=%0d want 1 1", term_valid, term);
        end
        tick();
        checks++;
        if (term_valid !== 1'b1 || term !== 32'd2 || done !== 1'b1) begin
            failures++;
            $display("FAIL rst_fresh2 got tv=%b term=%0d done=%b want 1 2 1", term_valid, term, done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fib_add();
        test_sub();
        test_overflow_and_zero();
        test_back_to_back();
        test_unknown_op();
        test_max_n();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
